stepper_sequencer: RTL and testbench

STEPPER_SEQUENCER -- requirements
Module: stepper_sequencer

---
 rtl/stepper_sequencer.sv | 100 ++++++++++
 tb/tb_stepper_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_sequencer.sv
// Step-motor phase sequencer: a free-running prescaler paces steps through an eight-entry
// coil table, tracks a wrapping signed position and drops coil drive after an idle timeout.
module stepper_sequencer #(
  parameter int unsigned STEP_DIV   = 1000,
  parameter int unsigned HALF_STEP  = 0,
  parameter int unsigned IDLE_TICKS = 255
) (
  input  logic        system1000,
  input  logic        system1000_rstn,
  input  logic [1:0]  in,
  output logic [3:0]  result,
  output logic        step,
  output logic [15:0] position
);

  localparam int unsigned PrescW = $clog2(STEP_DIV);
  localparam int unsigned IdleW  = (IDLE_TICKS > 0) ? $clog2(IDLE_TICKS + 1) : 1;
  localparam logic [PrescW-1:0] PrescMax = PrescW'(STEP_DIV - 1);
  localparam logic [IdleW-1:0]  IdleMax  = IdleW'(IDLE_TICKS);
  localparam logic [2:0] Stride   = (HALF_STEP != 0) ? 3'd1 : 3'd2;
  // Full-step mode stays on odd phases so two coils are always driven.
  localparam logic [2:0] PhaseRst = (HALF_STEP != 0) ? 3'd0 : 3'd1;

  logic              run_q, dir_q;
  logic [PrescW-1:0] presc_q, presc_d;
  logic [2:0]        p_q, p_d;
  logic [15:0]       pos_q, pos_d;
  logic [IdleW-1:0]  idle_q, idle_d;
  logic              en_q, en_d;
  logic              step_q;
  logic [3:0]        result_q, result_d;
  logic              tick, exec;

  function automatic logic [3:0] phase_pattern(input logic [2:0] idx);
    logic [3:0] pat;
    unique case (idx)
      3'd0: pat = 4'b1000;
      3'd1: pat = 4'b1100;
      3'd2: pat = 4'b0100;
      3'd3: pat = 4'b0110;
      3'd4: pat = 4'b0010;
      3'd5: pat = 4'b0011;
      3'd6: pat = 4'b0001;
      3'd7: pat = 4'b1001;
    endcase
    return pat;
  endfunction

  always_comb begin
    tick    = (presc_q == PrescMax);
    exec    = tick && run_q;
    presc_d = tick ? '0 : presc_q + 1'b1;
    p_d     = p_q;
    pos_d   = pos_q;
    if (exec) begin
      p_d   = dir_q ? p_q + Stride : p_q - Stride;
      pos_d = dir_q ? pos_q + 16'd1 : pos_q - 16'd1;
    end
    idle_d = idle_q;
    en_d   = en_q;
    if (run_q) begin
      idle_d = '0;
      en_d   = 1'b1;
    end else if (tick && idle_q != IdleMax) begin
      // With IDLE_TICKS = 0 the counter is pinned at its maximum, so drive never drops.
      idle_d = idle_q + 1'b1;
      if (idle_d == IdleMax) en_d = 1'b0;
    end
    result_d = en_d ? phase_pattern(p_d) : 4'b0000;
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      run_q    <= 1'b0;
      dir_q    <= 1'b0;
      presc_q  <= '0;
      p_q      <= PhaseRst;
      pos_q    <= '0;
      idle_q   <= '0;
      en_q     <= 1'b0;
      step_q   <= 1'b0;
      result_q <= 4'b0000;
    end else begin
      run_q    <= in[1];
      dir_q    <= in[0];
      presc_q  <= presc_d;
      p_q      <= p_d;
      pos_q    <= pos_d;
      idle_q   <= idle_d;
      en_q     <= en_d;
      step_q   <= exec;
      result_q <= result_d;
    end
  end

  assign result   = result_q;
  assign step     = step_q;
  assign position = pos_q;

endmodule

// File: tb/tb_stepper_sequencer.sv
// Bench for stepper_sequencer: three instances share one stimulus stream and are compared every
// cycle against a coil-geometry model, with literal expectations for the key scenarios.
module tb_stepper_sequencer;

  localparam int N    = 3;
  localparam int Idle = 3;

  // Instance 0: half-step, instance 1: full-step, instance 2: fast half-step for position wrap.
  int div_c  [N] = '{4, 4, 2};
  int half_c [N] = '{1, 0, 1};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  in_s;
  logic [3:0]  res [N];
  logic        stp [N];
  logic [15:0] pos [N];

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_half [8] = '{4'b1100, 4'b0100, 4'b0110, 4'b0010,
                               4'b0011, 4'b0001, 4'b1001, 4'b1000};
  logic [3:0] exp_rev  [4] = '{4'b1001, 4'b0011, 4'b0110, 4'b1100};

  // Model state: previous-cycle command, cycle count, phase, position, idle ticks, drive.
  int         m_run [N], m_dir [N], m_cnt [N], m_p [N], m_pos [N], m_idle [N], m_en [N];
  int         m_step [N];
  logic [3:0] m_res [N];

  stepper_sequencer #(.STEP_DIV(4), .HALF_STEP(1), .IDLE_TICKS(Idle)) u_half (
    .system1000(clk), .system1000_rstn(rst_n), .in(in_s),
    .result(res[0]), .step(stp[0]), .position(pos[0])
  );
  stepper_sequencer #(.STEP_DIV(4), .HALF_STEP(0), .IDLE_TICKS(Idle)) u_full (
    .system1000(clk), .system1000_rstn(rst_n), .in(in_s),
    .result(res[1]), .step(stp[1]), .position(pos[1])
  );
  stepper_sequencer #(.STEP_DIV(2), .HALF_STEP(1), .IDLE_TICKS(Idle)) u_fast (
    .system1000(clk), .system1000_rstn(rst_n), .in(in_s),
    .result(res[2]), .step(stp[2]), .position(pos[2])
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Four coils on a ring; even phases drive one coil, odd phases drive it and its neighbour.
  function automatic logic [3:0] coils(input int p);
    logic [3:0] r;
    int k;
    r = 4'b0000;
    k = p / 2;
    r[3 - k] = 1'b1;
    if (p % 2 == 1) r[3 - ((k + 1) % 4)] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_run[i] = 0; m_dir[i] = 0; m_cnt[i] = 0; m_pos[i] = 0; m_idle[i] = 0;
      m_en[i] = 0; m_step[i] = 0; m_res[i] = 4'b0000;
      m_p[i] = (half_c[i] != 0) ? 0 : 1;
    end
  endtask

  task automatic model_edge(input int i);
    int s;
    bit tk;
    s  = (half_c[i] != 0) ? 1 : 2;
    tk = (m_cnt[i] == div_c[i] - 1);
    m_step[i] = (tk && m_run[i] != 0) ? 1 : 0;
    if (m_step[i] != 0) begin
      m_p[i]   = (m_p[i] + ((m_dir[i] != 0) ? s : 8 - s)) % 8;
      m_pos[i] = (m_pos[i] + ((m_dir[i] != 0) ? 1 : 65535)) % 65536;
    end
    if (m_run[i] != 0) begin
      m_idle[i] = 0;
      m_en[i]   = 1;
    end else if (tk && m_idle[i] < Idle) begin
      m_idle[i]++;
      if (m_idle[i] == Idle) m_en[i] = 0;
    end
    m_res[i] = (m_en[i] != 0) ? coils(m_p[i]) : 4'b0000;
    m_cnt[i] = (m_cnt[i] + 1) % div_c[i];
    m_run[i] = int'(in_s[1]);
    m_dir[i] = int'(in_s[0]);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else for (int i = 0; i < N; i++) model_edge(i);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        check($sformatf("result[%0d]", i), int'(res[i]), int'(m_res[i]));
        check($sformatf("step[%0d]", i), int'(stp[i]), m_step[i]);
        check($sformatf("position[%0d]", i), int'(pos[i]), m_pos[i]);
      end
    end
  end

  task automatic check_reset_outputs();
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst_result[%0d]", i), int'(res[i]), 0);
      check($sformatf("rst_step[%0d]", i), int'(stp[i]), 0);
      check($sformatf("rst_position[%0d]", i), int'(pos[i]), 0);
    end
  endtask

  // Reset asserted between edges; outputs are checked before any further edge arrives.
  task automatic do_reset(input logic [1:0] v);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    in_s  = v;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic wait_step(input int i, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (stp[i]) ok = 1'b1;
    end
  endtask

  initial begin
    bit ok;
    int n, cyc, zero_at, first;
    logic [3:0] last;

    in_s  = 2'b11;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs();
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Half-step forward through the whole table.
    n = 0;
    cyc = 0;
    while (n < 8 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (stp[0]) begin
        check($sformatf("half_seq%0d", n), int'(res[0]), int'(exp_half[n]));
        n++;
      end
    end
    check("half_steps", n, 8);
    check("half_pos", int'(pos[0]), 8);

    // Full-step reverse.
    do_reset(2'b10);
    for (int k = 0; k < 4; k++) begin
      wait_step(1, ok);
      check("rev_seen", int'(ok), 1);
      check($sformatf("rev_seq%0d", k), int'(res[1]), int'(exp_rev[k]));
    end
    check("rev_pos", int'(pos[1]), 16'hfffc);

    // Idle de-energize after three ticks, then reverse restart.
    do_reset(2'b11);
    wait_step(1, ok);
    wait_step(1, ok);
    check("idle_pre_seen", int'(ok), 1);
    in_s = 2'b00;
    zero_at = 0;
    last = 4'b0000;
    for (int c = 1; c <= 20 && zero_at == 0; c++) begin
      @(negedge clk);
      if (res[1] == 4'b0000) zero_at = c;
      else last = res[1];
    end
    check("idle_off_cycle", zero_at, 12);
    check("idle_hold", int'(last), 4'b0011);
    check("idle_pos", int'(pos[1]), 2);
    in_s = 2'b10;
    @(negedge clk);
    check("reen_early", int'(res[1]), 0);
    @(negedge clk);
    check("reen_pattern", int'(res[1]), 4'b0011);
    wait_step(1, ok);
    check("reen_step_seen", int'(ok), 1);
    check("reen_step_res", int'(res[1]), 4'b0110);
    check("reen_step_pos", int'(pos[1]), 1);

    // Position wrap at the signed limit on the fast instance.
    do_reset(2'b11);
    ok = 1'b0;
    for (int c = 0; c < 70000 && !ok; c++) begin
      @(negedge clk);
      if (m_pos[2] == 32767) ok = 1'b1;
    end
    check("wrap_reached", int'(ok), 1);
    check("wrap_max", int'(pos[2]), 16'h7fff);
    wait_step(2, ok);
    check("wrap_fwd", int'(pos[2]), 16'h8000);
    in_s = 2'b10;
    wait_step(2, ok);
    check("wrap_back", int'(pos[2]), 16'h7fff);

    // Random command segments, long enough for idle timeouts to occur.
    for (int seg = 0; seg < 40; seg++) begin
      in_s = 2'($urandom_range(0, 3));
      repeat ($urandom_range(1, 30)) @(negedge clk);
    end

    // Reset in the middle of a run, then time the first step after release.
    in_s = 2'b11;
    repeat (9) @(negedge clk);
    do_reset(2'b11);
    first = 0;
    for (int c = 1; c <= 20 && first == 0; c++) begin
      @(negedge clk);
      if (stp[0]) first = c;
    end
    check("first_step_cycle", first, 5);
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
